// File: rtl/adc_capture_ctrl.sv
// ADC acquisition sequencer: pre-trigger, armed and post-trigger forwarding with a single holding register.
// Optional build macro ADC_CAPTURE_EXT_TRIG_EN adds a synchronised external trigger input.
module adc_capture_ctrl #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 s_axis_tvalid,
    input  logic [31:0]          s_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [31:0]          m_axis_tdata,
    output logic                 m_axis_tlast,
    input  logic                 arm,
    input  logic                 abort,
    input  logic [15:0]          trig_level,
    input  logic                 trig_falling,
    input  logic [CNT_WIDTH-1:0] pre_len,
    input  logic [CNT_WIDTH-1:0] post_len,
`ifdef ADC_CAPTURE_EXT_TRIG_EN
    input  logic                 ext_trig,
`endif
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [CNT_WIDTH-1:0] trig_pos
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PRE   = 3'd1;
    localparam logic [2:0] ST_ARMED = 3'd2;
    localparam logic [2:0] ST_POST  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [2:0]            state_q, state_d;
    logic [CNT_WIDTH-1:0]  sample_cnt_q, sample_cnt_d;
    logic [CNT_WIDTH-1:0]  post_cnt_q, post_cnt_d;
    logic [CNT_WIDTH-1:0]  trig_pos_q, trig_pos_d;
    logic signed [15:0]    prev_q;
    logic                  first_q, first_d;
    logic                  overflow_q, overflow_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic [31:0]           tdata_q, tdata_d;

    logic                  fwd, fwd_last, level_hit, trig_ext;
    logic signed [15:0]    cur_s, level_s;

    assign cur_s   = s_axis_tdata[15:0];
    assign level_s = trig_level;

    always_comb begin
        if (trig_falling) level_hit = (prev_q >= level_s) && (cur_s < level_s);
        else              level_hit = (prev_q < level_s) && (cur_s >= level_s);
    end

`ifdef ADC_CAPTURE_EXT_TRIG_EN
    // Two flops for metastability, third flop holds the previous synchronised level for edge detection.
    logic [2:0] ext_sync_q;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) ext_sync_q <= 3'b000;
        else          ext_sync_q <= {ext_sync_q[1:0], ext_trig};
    end
    assign trig_ext = ext_sync_q[1] & ~ext_sync_q[2];
`else
    assign trig_ext = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        post_cnt_d   = post_cnt_q;
        trig_pos_d   = trig_pos_q;
        first_d      = first_q;
        overflow_d   = overflow_q;
        fwd          = 1'b0;
        fwd_last     = 1'b0;
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        state_d      = (pre_len == '0) ? ST_ARMED : ST_PRE;
                        sample_cnt_d = '0;
                        overflow_d   = 1'b0;
                        first_d      = 1'b1;
                    end
                end
                ST_PRE: begin
                    if (s_axis_tvalid) begin
                        fwd          = 1'b1;
                        sample_cnt_d = sample_cnt_q + CNT_ONE;
                        if (sample_cnt_q + CNT_ONE == pre_len) state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (s_axis_tvalid) begin
                        fwd          = 1'b1;
                        sample_cnt_d = sample_cnt_q + CNT_ONE;
                        first_d      = 1'b0;
                        // prev only becomes meaningful for the level trigger after one ARMED sample.
                        if (trig_ext || (level_hit && !first_q)) begin
                            trig_pos_d = sample_cnt_q;
                            post_cnt_d = CNT_ONE;
                            if (post_len <= CNT_ONE) begin
                                fwd_last = 1'b1;
                                state_d  = ST_DONE;
                            end else begin
                                state_d  = ST_POST;
                            end
                        end
                    end
                end
                ST_POST: begin
                    if (s_axis_tvalid) begin
                        fwd        = 1'b1;
                        post_cnt_d = post_cnt_q + CNT_ONE;
                        if (post_cnt_q + CNT_ONE >= post_len) begin
                            fwd_last = 1'b1;
                            state_d  = ST_DONE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Single holding register: a new beat overwrites an unaccepted one and flags overflow.
    always_comb begin
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tdata_d  = tdata_q;
        if (fwd) begin
            tvalid_d = 1'b1;
            tlast_d  = fwd_last;
            tdata_d  = s_axis_tdata;
        end else if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            sample_cnt_q <= '0;
            post_cnt_q   <= '0;
            trig_pos_q   <= '0;
            prev_q       <= '0;
            first_q      <= 1'b0;
            overflow_q   <= 1'b0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            post_cnt_q   <= post_cnt_d;
            trig_pos_q   <= trig_pos_d;
            first_q      <= first_d;
            overflow_q   <= (fwd && tvalid_q && !m_axis_tready) ? 1'b1 : overflow_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            tdata_q      <= tdata_d;
            if (s_axis_tvalid) prev_q <= cur_s;
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = (state_q == ST_PRE) || (state_q == ST_ARMED) || (state_q == ST_POST);
    assign done          = (state_q == ST_DONE);
    assign overflow      = overflow_q;
    assign trig_pos      = trig_pos_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed self-checking bench for adc_capture_ctrl; ext-trigger scenario only when ADC_CAPTURE_EXT_TRIG_EN is defined.
module tb_adc_capture_ctrl;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        s_axis_tvalid;
    logic [31:0] s_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        arm, abort;
    logic [15:0] trig_level;
    logic        trig_falling;
    logic [31:0] pre_len, post_len;
    logic        busy, done, overflow;
    logic [31:0] trig_pos;
`ifdef ADC_CAPTURE_EXT_TRIG_EN
    logic        ext_trig;
`endif

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    adc_capture_ctrl #(.CNT_WIDTH(32)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .arm(arm), .abort(abort), .trig_level(trig_level), .trig_falling(trig_falling),
        .pre_len(pre_len), .post_len(post_len),
`ifdef ADC_CAPTURE_EXT_TRIG_EN
        .ext_trig(ext_trig),
`endif
        .busy(busy), .done(done), .overflow(overflow), .trig_pos(trig_pos)
    );

    // Present one sample, advance one clock, leave outputs settled for checking.
    task automatic step(input logic signed [15:0] smp);
        s_axis_tdata = {16'hBEEF, smp};
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0; s_axis_tvalid = 1'b1; s_axis_tdata = 32'h0; m_axis_tready = 1'b1;
        arm = 1'b0; abort = 1'b0; trig_level = 16'd0; trig_falling = 1'b0;
        pre_len = 32'd0; post_len = 32'd0;
`ifdef ADC_CAPTURE_EXT_TRIG_EN
        ext_trig = 1'b0;
`endif
        repeat (3) @(posedge aclk);
        #1;
        checks++; if ({m_axis_tvalid, m_axis_tlast, busy, done, overflow} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {m_axis_tvalid, m_axis_tlast, busy, done, overflow}); end
        checks++; if (m_axis_tdata !== 32'h0 || trig_pos !== 32'h0) begin errors++; $display("FAIL reset_data got tdata=%h trig_pos=%0d exp 0/0", m_axis_tdata, trig_pos); end
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic test_rising();
        logic signed [15:0] smp [9] = '{16'sd0, 16'sd10, 16'sd20, 16'sd30, 16'sd150, 16'sd50, 16'sd120, 16'sd130, 16'sd140};
        pre_len = 32'd4; post_len = 32'd3; trig_level = 16'd100; trig_falling = 1'b0;
        arm = 1'b1; step(-16'sd7); arm = 1'b0;
        checks++; if (busy !== 1'b1 || m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rise_arm got busy=%b tvalid=%b exp 1/0", busy, m_axis_tvalid); end
        for (int i = 0; i < 9; i++) begin
            arm = (i == 1);
            step(smp[i]);
            checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== {16'hBEEF, smp[i]}) begin errors++; $display("FAIL rise_beat%0d got v=%b d=%h exp 1/%h", i, m_axis_tvalid, m_axis_tdata, {16'hBEEF, smp[i]}); end
            checks++; if (m_axis_tlast !== (i == 8)) begin errors++; $display("FAIL rise_tlast%0d got %b exp %b", i, m_axis_tlast, (i == 8)); end
        end
        arm = 1'b0;
        checks++; if (done !== 1'b1 || busy !== 1'b0 || trig_pos !== 32'd6) begin errors++; $display("FAIL rise_end got done=%b busy=%b trig_pos=%0d exp 1/0/6", done, busy, trig_pos); end
        step(16'sd0);
        checks++; if (m_axis_tvalid !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL rise_idle got tvalid=%b done=%b exp 0/1", m_axis_tvalid, done); end
    endtask

    task automatic test_falling();
        logic signed [15:0] smp [4] = '{16'sd5, 16'sd3, -16'sd1, -16'sd4};
        pre_len = 32'd0; post_len = 32'd2; trig_level = 16'd0; trig_falling = 1'b1;
        arm = 1'b1; step(16'sd9); arm = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL fall_arm got busy=%b done=%b exp 1/0", busy, done); end
        for (int i = 0; i < 4; i++) begin
            step(smp[i]);
            checks++; if (m_axis_tdata !== {16'hBEEF, smp[i]} || m_axis_tlast !== (i == 3)) begin errors++; $display("FAIL fall_beat%0d got d=%h l=%b exp %h/%b", i, m_axis_tdata, m_axis_tlast, {16'hBEEF, smp[i]}, (i == 3)); end
        end
        checks++; if (trig_pos !== 32'd2 || done !== 1'b1) begin errors++; $display("FAIL fall_end got trig_pos=%0d done=%b exp 2/1", trig_pos, done); end
        trig_falling = 1'b0;
    endtask

    task automatic test_backpressure();
        logic signed [15:0] smp [6] = '{-16'sd5, -16'sd3, 16'sd7, 16'sd8, 16'sd9, 16'sd10};
        pre_len = 32'd1; post_len = 32'd4; trig_level = 16'd0;
        arm = 1'b1; step(-16'sd9); arm = 1'b0;
        for (int i = 0; i < 6; i++) begin
            m_axis_tready = !(i >= 3);
            step(smp[i]);
            checks++; if (m_axis_tdata !== {16'hBEEF, smp[i]} || m_axis_tlast !== (i == 5)) begin errors++; $display("FAIL bp_beat%0d got d=%h l=%b exp %h/%b", i, m_axis_tdata, m_axis_tlast, {16'hBEEF, smp[i]}, (i == 5)); end
        end
        checks++; if (overflow !== 1'b1 || done !== 1'b1 || trig_pos !== 32'd2) begin errors++; $display("FAIL bp_end got ovf=%b done=%b trig_pos=%0d exp 1/1/2", overflow, done, trig_pos); end
        m_axis_tready = 1'b1;
        step(16'sd0);
        checks++; if (m_axis_tvalid !== 1'b0 || overflow !== 1'b1) begin errors++; $display("FAIL bp_drain got tvalid=%b ovf=%b exp 0/1", m_axis_tvalid, overflow); end
        arm = 1'b1; step(16'sd0); arm = 1'b0;
        checks++; if (overflow !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL bp_rearm got ovf=%b busy=%b exp 0/1", overflow, busy); end
        abort = 1'b1; step(16'sd0); abort = 1'b0;
        checks++; if (busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL bp_abort got busy=%b tvalid=%b exp 0/0", busy, m_axis_tvalid); end
    endtask

    task automatic test_zero_len();
        pre_len = 32'd0; post_len = 32'd0; trig_level = 16'd0;
        arm = 1'b1; step(-16'sd1); arm = 1'b0;
        step(-16'sd2);
        checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL zero_first got v=%b l=%b busy=%b exp 1/0/1", m_axis_tvalid, m_axis_tlast, busy); end
        step(16'sd3);
        checks++; if (m_axis_tdata !== 32'hBEEF0003 || m_axis_tlast !== 1'b1 || done !== 1'b1 || trig_pos !== 32'd1) begin errors++; $display("FAIL zero_trig got d=%h l=%b done=%b pos=%0d exp BEEF0003/1/1/1", m_axis_tdata, m_axis_tlast, done, trig_pos); end
        step(16'sd4);
        checks++; if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin errors++; $display("FAIL zero_after got v=%b l=%b exp 0/0", m_axis_tvalid, m_axis_tlast); end
    endtask

    task automatic test_abort();
        pre_len = 32'd0; post_len = 32'd5; trig_level = 16'd0;
        arm = 1'b1; step(-16'sd1); arm = 1'b0;
        step(-16'sd4);
        m_axis_tready = 1'b0; abort = 1'b1; arm = 1'b1;
        step(16'sd6);
        abort = 1'b0; arm = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_state got busy=%b done=%b exp 0/0", busy, done); end
        checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hBEEFFFFC || m_axis_tlast !== 1'b0) begin errors++; $display("FAIL abort_held got v=%b d=%h l=%b exp 1/BEEFFFFC/0", m_axis_tvalid, m_axis_tdata, m_axis_tlast); end
        m_axis_tready = 1'b1;
        step(16'sd7);
        checks++; if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_drain got v=%b busy=%b exp 0/0", m_axis_tvalid, busy); end
        post_len = 32'd1;
        arm = 1'b1; step(-16'sd1); arm = 1'b0;
        step(-16'sd2);
        step(16'sd5);
        checks++; if (m_axis_tdata !== 32'hBEEF0005 || m_axis_tlast !== 1'b1 || done !== 1'b1 || trig_pos !== 32'd1) begin errors++; $display("FAIL abort_rearm got d=%h l=%b done=%b pos=%0d exp BEEF0005/1/1/1", m_axis_tdata, m_axis_tlast, done, trig_pos); end
    endtask

`ifdef ADC_CAPTURE_EXT_TRIG_EN
    task automatic test_ext_trig();
        pre_len = 32'd0; post_len = 32'd2; trig_level = 16'd1000;
        arm = 1'b1; step(16'sd0); arm = 1'b0;
        step(16'sd0); step(16'sd0);
        ext_trig = 1'b1;
        step(16'sd0); step(16'sd0);
        checks++; if (busy !== 1'b1 || done !== 1'b0 || m_axis_tlast !== 1'b0) begin errors++; $display("FAIL ext_early got busy=%b done=%b l=%b exp 1/0/0", busy, done, m_axis_tlast); end
        step(16'sd0);
        checks++; if (trig_pos !== 32'd4) begin errors++; $display("FAIL ext_pos got %0d exp 4", trig_pos); end
        ext_trig = 1'b0;
        step(16'sd0);
        checks++; if (m_axis_tlast !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL ext_end got l=%b done=%b exp 1/1", m_axis_tlast, done); end
    endtask
`endif

    task automatic test_async_reset();
        pre_len = 32'd0; post_len = 32'd10; trig_level = 16'd0;
        arm = 1'b1; step(-16'sd1); arm = 1'b0;
        step(-16'sd2); step(16'sd5); step(16'sd6);
        checks++; if (busy !== 1'b1 || m_axis_tvalid !== 1'b1 || trig_pos !== 32'd1) begin errors++; $display("FAIL areset_pre got busy=%b v=%b pos=%0d exp 1/1/1", busy, m_axis_tvalid, trig_pos); end
        #2;
        aresetn = 1'b0;
        #1;
        checks++; if ({m_axis_tvalid, m_axis_tlast, busy, done, overflow} !== 5'b0 || m_axis_tdata !== 32'h0 || trig_pos !== 32'h0) begin errors++; $display("FAIL areset_now got flags=%b d=%h pos=%0d exp 0", {m_axis_tvalid, m_axis_tlast, busy, done, overflow}, m_axis_tdata, trig_pos); end
        @(negedge aclk);
        aresetn = 1'b1;
        step(16'sd7);
        checks++; if (busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL areset_after got busy=%b v=%b exp 0/0", busy, m_axis_tvalid); end
    endtask

    initial begin
        test_reset();
        test_rising();
        test_falling();
        test_backpressure();
        test_zero_len();
        test_abort();
`ifdef ADC_CAPTURE_EXT_TRIG_EN
        test_ext_trig();
`endif
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
